instr_encoder: RTL and testbench

//   Inverse of the ALU-control decode path. It turns symbolic op requests (op, regs, imm)

---
 rtl/instr_encoder.sv | 152 +++++++++++++++
 tb/tb_instr_encoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// LEGv8 instruction encoder: symbolic op requests are encoded, buffered in a FIFO,
// and streamed out with a byte address that advances by 4 per consumed word.
module instr_encoder #(
  parameter int unsigned          DEPTH  = 4,
  parameter int unsigned          ADDR_W = 8,
  parameter logic [ADDR_W-1:0]    BASE   = '0
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              Flush,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [3:0]        ReqOp,
  input  logic [4:0]        Rd,
  input  logic [4:0]        Rn,
  input  logic [4:0]        Rm,
  input  logic [25:0]       Imm,
  output logic              InstrValid,
  input  logic              InstrReady,
  output logic [31:0]       Instr,
  output logic [ADDR_W-1:0] InstrAddr,
  output logic              Error
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         mem_q [DEPTH];
  logic [31:0]         mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                error_q, error_d;

  logic [31:0]         enc_word;
  logic                legal;
  logic                accept;
  logic                push;
  logic                pop;

  always_comb begin
    enc_word = '0;
    legal    = 1'b1;
    case (ReqOp)
      4'd0:    enc_word = {11'b10001011000, Rm, 6'b000000, Rn, Rd};
      4'd1:    enc_word = {11'b11001011000, Rm, 6'b000000, Rn, Rd};
      4'd2:    enc_word = {11'b10001010000, Rm, 6'b000000, Rn, Rd};
      4'd3:    enc_word = {11'b10101010000, Rm, 6'b000000, Rn, Rd};
      4'd4:    enc_word = {11'b11010011011, 5'b00000, Imm[5:0], Rn, Rd};
      4'd5:    enc_word = {11'b11010011010, 5'b00000, Imm[5:0], Rn, Rd};
      4'd6:    enc_word = {11'b11111000010, Imm[8:0], 2'b00, Rn, Rd};
      4'd7:    enc_word = {11'b11111000000, Imm[8:0], 2'b00, Rn, Rd};
      4'd8:    enc_word = {8'b10110100, Imm[18:0], Rd};
      4'd9:    enc_word = {6'b000101, Imm[25:0]};
      default: legal    = 1'b0;
    endcase
  end

  // Ready/valid come only from registered state, so a pop never frees a slot in the same cycle.
  assign ReqReady   = (state_q != ST_FULL);
  assign InstrValid = (state_q != ST_EMPTY);
  assign Instr      = mem_q[rd_ptr_q];
  assign InstrAddr  = addr_q;
  assign Error      = error_q;

  assign accept = ReqValid & ReqReady;
  assign push   = accept & legal;
  assign pop    = InstrValid & InstrReady;

  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    error_d  = accept & ~legal;

    if (Flush) begin
      state_d  = ST_EMPTY;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      addr_d   = BASE;
      error_d  = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = enc_word;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        addr_d   = addr_q + ADDR_W'(4);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end

      case (state_q)
        ST_EMPTY: begin
          if (push) state_d = ST_PARTIAL;
        end
        ST_PARTIAL: begin
          if (push && !pop && count_q == CNT_W'(DEPTH - 1)) begin
            state_d = ST_FULL;
          end else if (pop && !push && count_q == CNT_W'(1)) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) state_d = ST_PARTIAL;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= BASE;
      error_q  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      error_q  <= error_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed LEGv8 vectors plus randomized traffic checked
// against a queue-based reference model that encodes words with integer arithmetic.
module tb_instr_encoder;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 8;
  localparam logic [7:0]  BASE   = 8'h00;

  logic        CLOCK;
  logic        RESET;
  logic        Flush;
  logic        ReqValid;
  logic        ReqReady;
  logic [3:0]  ReqOp;
  logic [4:0]  Rd;
  logic [4:0]  Rn;
  logic [4:0]  Rm;
  logic [25:0] Imm;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instr;
  logic [7:0]  InstrAddr;
  logic        Error;

  instr_encoder #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .BASE  (BASE)
  ) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .Flush     (Flush),
    .ReqValid  (ReqValid),
    .ReqReady  (ReqReady),
    .ReqOp     (ReqOp),
    .Rd        (Rd),
    .Rn        (Rn),
    .Rm        (Rm),
    .Imm       (Imm),
    .InstrValid(InstrValid),
    .InstrReady(InstrReady),
    .Instr     (Instr),
    .InstrAddr (InstrAddr),
    .Error     (Error)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] exp_q[$];
  int          exp_addr;
  logic        exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Field layout from the ISA tables, built arithmetically.
  function automatic logic [31:0] ref_encode(input int op, input int rd, input int rn,
                                             input int rm, input int imm);
    longint w;
    int opc11[8] = '{'h458, 'h658, 'h450, 'h550, 'h69B, 'h69A, 'h7C2, 'h7C0};
    w = 0;
    if (op <= 3)       w = opc11[op] * 2**21 + rm * 2**16 + rn * 2**5 + rd;
    else if (op <= 5)  w = opc11[op] * 2**21 + (imm % 64) * 2**10 + rn * 2**5 + rd;
    else if (op <= 7)  w = opc11[op] * 2**21 + (imm % 512) * 2**12 + rn * 2**5 + rd;
    else if (op == 8)  w = longint'('hB4) * 2**24 + (imm % 2**19) * 2**5 + rd;
    else if (op == 9)  w = 5 * 2**26 + (imm % 2**26);
    return w[31:0];
  endfunction

  task automatic model_clear();
    exp_q.delete();
    exp_addr = BASE;
    exp_err  = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 32'(InstrValid), 32'(exp_q.size() != 0));
    check({tag, ".ready"}, 32'(ReqReady), 32'(exp_q.size() != DEPTH));
    check({tag, ".addr"},  32'(InstrAddr), 32'(exp_addr));
    check({tag, ".err"},   32'(Error), 32'(exp_err));
    if (exp_q.size() != 0) check({tag, ".instr"}, Instr, exp_q[0]);
  endtask

  // One clock: drive, advance the model across the edge, sample 1 time unit later.
  task automatic cycle(input string tag, input bit v, input int op, input int rd,
                       input int rn, input int rm, input int imm, input bit rdy,
                       input bit fl);
    bit acc, pp;
    ReqValid = v; ReqOp = 4'(op); Rd = 5'(rd); Rn = 5'(rn); Rm = 5'(rm);
    Imm = 26'(imm); InstrReady = rdy; Flush = fl;
    acc = v && (exp_q.size() < DEPTH);
    pp  = rdy && (exp_q.size() > 0);
    @(posedge CLOCK);
    #1;
    if (fl) begin
      model_clear();
    end else begin
      if (pp) begin
        void'(exp_q.pop_front());
        exp_addr = (exp_addr + 4) % 256;
      end
      if (acc && op <= 9) exp_q.push_back(ref_encode(op, rd, rn, rm, imm));
      exp_err = acc && (op > 9);
    end
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input bit rdy);
    cycle(tag, 1'b0, 0, 0, 0, 0, 0, rdy, 1'b0);
  endtask

  initial begin
    int op, rv;
    RESET = 1'b0; Flush = 1'b0; ReqValid = 1'b0; ReqOp = '0; Rd = '0; Rn = '0;
    Rm = '0; Imm = '0; InstrReady = 1'b0;
    model_clear();
    #12;
    check("rst.valid", 32'(InstrValid), 32'd0);
    check("rst.ready", 32'(ReqReady), 32'd1);
    check("rst.instr", Instr, 32'd0);
    check("rst.addr",  32'(InstrAddr), 32'(BASE));
    check("rst.err",   32'(Error), 32'd0);
    @(negedge CLOCK);
    RESET = 1'b1;
    @(posedge CLOCK);
    #1;

    // ADD, one-cycle latency
    cycle("add", 1'b1, 0, 1, 2, 3, 0, 1'b1, 1'b0);
    check("add.word", Instr, 32'h8B030041);
    check("add.addr0", 32'(InstrAddr), 32'h00);
    idle("add.pop", 1'b1);

    // Stream of four formats, address sequence from BASE after a flush
    cycle("flush0", 1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    cycle("ldur", 1'b1, 6, 9, 22, 0, 64, 1'b0, 1'b0);
    cycle("lsl",  1'b1, 4, 1, 2, 0, 4, 1'b0, 1'b0);
    cycle("cbz",  1'b1, 8, 3, 0, 0, 5, 1'b0, 1'b0);
    cycle("b",    1'b1, 9, 0, 0, 0, 'h10, 1'b0, 1'b0);
    check("stream.w0", Instr, 32'hF84402C9);
    check("stream.a0", 32'(InstrAddr), 32'h00);
    idle("drain1", 1'b1);
    check("stream.w1", Instr, 32'hD3601041);
    check("stream.a1", 32'(InstrAddr), 32'h04);
    idle("drain2", 1'b1);
    check("stream.w2", Instr, 32'hB40000A3);
    check("stream.a2", 32'(InstrAddr), 32'h08);
    idle("drain3", 1'b1);
    check("stream.w3", Instr, 32'h14000010);
    check("stream.a3", 32'(InstrAddr), 32'h0C);
    idle("drain4", 1'b1);

    // Backpressure: DEPTH+1 pushes with consumer stalled
    for (int i = 0; i < DEPTH + 1; i++)
      cycle("fill", 1'b1, i % 4, i, i + 1, i + 2, 0, 1'b0, 1'b0);
    check("full.ready", 32'(ReqReady), 32'd0);
    // Pop while full: the held request must not sneak in the same cycle
    cycle("full.popnopush", 1'b1, 1, 7, 7, 7, 0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) idle("drainfull", 1'b1);

    // Illegal op
    cycle("ill", 1'b1, 12, 1, 1, 1, 0, 1'b0, 1'b0);
    check("ill.pulse", 32'(Error), 32'd1);
    cycle("ill.add", 1'b1, 0, 4, 5, 6, 0, 1'b0, 1'b0);
    check("ill.pulse_end", 32'(Error), 32'd0);
    idle("ill.pop", 1'b1);

    // Flush on a full FIFO with push and pop requested
    for (int i = 0; i < DEPTH; i++) cycle("ffill", 1'b1, 2, i, i, i, 0, 1'b0, 1'b0);
    cycle("flushfull", 1'b1, 0, 1, 2, 3, 0, 1'b1, 1'b1);
    check("flush.valid", 32'(InstrValid), 32'd0);
    check("flush.ready", 32'(ReqReady), 32'd1);
    check("flush.addr",  32'(InstrAddr), 32'(BASE));

    // Asynchronous reset mid-cycle with three words buffered
    idle("pre", 1'b1);
    for (int i = 0; i < 3; i++) cycle("rfill", 1'b1, 3, i, i, i, 0, 1'b0, 1'b0);
    #2;
    RESET = 1'b0;
    #1;
    check("areset.valid", 32'(InstrValid), 32'd0);
    check("areset.ready", 32'(ReqReady), 32'd1);
    check("areset.instr", Instr, 32'd0);
    check("areset.addr",  32'(InstrAddr), 32'(BASE));
    model_clear();
    @(negedge CLOCK);
    RESET = 1'b1;

    // 64 pops wrap the byte address back to BASE
    cycle("wrap.first", 1'b1, 0, 1, 1, 1, 0, 1'b1, 1'b0);
    for (int i = 0; i < 63; i++) cycle("wrap", 1'b1, 1, 2, 2, 2, 0, 1'b1, 1'b0);
    check("wrap.fc", 32'(InstrAddr), 32'hFC);
    cycle("wrap.last", 1'b1, 1, 2, 2, 2, 0, 1'b1, 1'b0);
    check("wrap.00", 32'(InstrAddr), 32'h00);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(15, 0);
      if ($urandom_range(3, 0) != 0) op = $urandom_range(9, 0);
      rv = $urandom_range(31, 0);
      cycle("rand", 1'($urandom_range(1, 0)), op, $urandom_range(31, 0),
            $urandom_range(31, 0), $urandom_range(31, 0), int'($urandom() & 32'h03FF_FFFF),
            1'($urandom_range(2, 0) != 0), (rv == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
